slowmem_master: RTL and testbench
=================================

# slowmem_master

Initiator-side controller for the `slowmem` strobe/mfc protocol. It turns single-word CPU load, store and fetch requests into correctly paced `strobe`/`rnotw` transactions. It owns an optional 8-line direct-mapped write-through cache and a read watchdog. It sits between a pipeline memory stage and `slowmem`, replacing direct `m[]` array access.

## Interface
- `LINES`, default 8: cache lines; must be a power of 2. Index is `addr[2:0]`, tag is `addr[15:3]`.
- `TIMEOUT`, default 16: maximum cycles spent in RD_WAIT before a read is aborted.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in 1: CPU request; held by the CPU until `ack`.
- `we` in 1: 1 = store, 0 = load; valid with `req`.
- `cpu_addr` in 16: word address.
- `cpu_wdata` in 16: store data.
- `flush` in 1: invalidate all cache lines; sampled only in IDLE.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: high with `ack` when a read timed out.
- `cpu_rdata` out 16: load data; valid while `ack`=1.
- `busy` out 1: high in any state other than IDLE.
- `mem_addr` out 16, `mem_wdata` out 16, `mem_rnotw` out 1, `mem_strobe` out 1: drive `slowmem`.
- `mem_mfc` in 1, `mem_rdata` in 16: from `slowmem`.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT. All outputs are registered.
- A request is accepted only at a clock edge where state=IDLE, `ack`=0 and `req`=1. `req` is ignored during the `ack` cycle.
- **Load hit** (valid and tag match): `ack`=1 and `cpu_rdata`=line data next cycle. No memory traffic. State stays IDLE.
- **Load miss**: drive `mem_strobe`=1, `mem_rnotw`=1, `mem_addr`=`cpu_addr` for exactly one cycle (RD_ISSUE), then go to RD_WAIT with `mem_strobe`=0.
  - `mem_strobe` is never held high for more than one cycle. `slowmem` restarts a read on every strobed cycle.
- **RD_WAIT**:
  - On `mem_mfc`=1: latch `mem_rdata`, fill the line (valid=1, tag), pulse `ack`, go to IDLE.
  - Watchdog: counts cycles in RD_WAIT. On reaching `TIMEOUT`: pulse `ack` and `err`, set `cpu_rdata`=16'hFFFF, leave the line untouched, go to IDLE.
- **Store**: drive `mem_strobe`=1, `mem_rnotw`=0, `mem_addr`, `mem_wdata` for one cycle (WRITE). Write-allocate: the line is written (valid=1, tag, data) at the same edge. `ack` pulses the following cycle. Stores never wait for `mfc`.
- `mem_mfc` is sampled only in RD_WAIT. A stray, X or late `mfc` in any other state is ignored.
- `flush` in IDLE clears all valid bits in one edge.
  - If `flush` and `req` are both present at the same edge, the flush applies first and the request is then processed against the empty cache (a load misses).

## Timing
- Reset values: `ack`=0, `err`=0, `cpu_rdata`=0, `busy`=0, `mem_strobe`=0, `mem_rnotw`=1, `mem_addr`=0, `mem_wdata`=0, all valid bits 0, state IDLE, watchdog 0.
- Request accepted at edge T0.
- Load hit: `ack` is high in cycle T0→T1.
- Store: strobe is high in T0→T1; `slowmem` writes at T1; `ack` is high in T1→T2.
- Load miss against `MEMDELAY`=4:
  - Strobe is high in T0→T1; `slowmem` latches at T1.
  - `mfc` is high in T5→T6; `ack` is high in T6→T7 (6-cycle latency).
- Timeout: `ack` and `err` are high exactly `TIMEOUT` cycles after entering RD_WAIT.
- Reset asserted mid-transaction forces reset values immediately. Any later `mfc` from the abandoned read is ignored.
- Back-to-back requests: the next accept is possible at the edge after the `ack` cycle.

## Configuration
- `SLOWMEM_MASTER_CACHE_EN` defined:
  - Cache is built as described.
- Not defined:
  - No tag, valid or data arrays are built.
  - Every load takes the miss path.
  - Stores behave identically apart from having no allocate.
  - `flush` is accepted and has no effect.

## Test plan
- Memory word 0x0010 holds 0x1234; load 0x0010 from reset -> one strobe cycle with `rnotw`=1, `ack` 6 cycles after accept, `cpu_rdata`=0x1234, `err`=0.
- Repeat load 0x0010 (CACHE_EN) -> `ack` the next cycle, no strobe, data 0x1234. Without CACHE_EN -> 6-cycle miss path again.
- Store 0xBEEF to 0x0010 -> one strobe cycle with `rnotw`=0 and `mem_wdata`=0xBEEF, `ack` the next cycle. Then load 0x0010 -> hit returning 0xBEEF, and the memory word equals 0xBEEF.
- Load 0x0018 (same index 0) after 0x0010 is cached -> miss, line replaced. A following load of 0x0010 -> miss again. After `flush`, load 0x0018 -> miss.
- `mem_mfc` forced to 0 -> `ack` and `err` high 16 cycles into RD_WAIT, `cpu_rdata`=0xFFFF, state returns to IDLE.
- Pulse `reset` two cycles into RD_WAIT -> all outputs at reset values, the stray `mfc` pulse is ignored, and a subsequent load completes correctly.

Source files
------------

// File: rtl/slowmem_master.sv
// Initiator for the slowmem strobe/mfc protocol with a read watchdog.
// Define SLOWMEM_MASTER_CACHE_EN to build the direct-mapped write-through cache.
module slowmem_master #(
  parameter int LINES   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        flush,
  output logic        ack,
  output logic        err,
  output logic [15:0] cpu_rdata,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rnotw,
  output logic        mem_strobe,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;

  state_t           state, state_nx;
  logic [WDW-1:0]   wdog, wdog_nx;
  logic             ack_nx, err_nx, busy_nx, strobe_nx, rnotw_nx;
  logic [15:0]      rdata_nx, addr_nx, wdata_nx;
  logic             accept;
  logic             hit;
  logic [15:0]      hit_data;

  // The ack cycle blocks acceptance so a request still held from the previous
  // transaction is not taken twice.
  assign accept = (state == IDLE) && !ack && req;

`ifdef SLOWMEM_MASTER_CACHE_EN
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 16 - IDXW;

  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [15:0]      data_mem [LINES];
  logic [IDXW-1:0]  req_idx, fill_idx;
  logic             alloc, fill;

  assign req_idx  = cpu_addr[IDXW-1:0];
  assign fill_idx = mem_addr[IDXW-1:0];
  assign alloc    = accept && we;
  assign fill     = (state == RD_WAIT) && mem_mfc;
  // A flush in the same cycle empties the cache before the lookup.
  assign hit      = !flush && valid[req_idx] && (tag_mem[req_idx] == cpu_addr[15:IDXW]);
  assign hit_data = data_mem[req_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if ((state == IDLE) && flush)
        valid <= '0;
      if (alloc)
        valid[req_idx] <= 1'b1;
      else if (fill)
        valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_mem[req_idx]  <= cpu_addr[15:IDXW];
      data_mem[req_idx] <= cpu_wdata;
    end else if (fill) begin
      tag_mem[fill_idx]  <= mem_addr[15:IDXW];
      data_mem[fill_idx] <= mem_rdata;
    end
  end
`else
  localparam int unused_lines = LINES;
  logic unused_flush;

  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif

  always_comb begin
    state_nx  = state;
    wdog_nx   = wdog;
    ack_nx    = 1'b0;
    err_nx    = 1'b0;
    strobe_nx = 1'b0;
    rnotw_nx  = 1'b1;
    rdata_nx  = cpu_rdata;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (we) begin
            state_nx  = WRITE;
            strobe_nx = 1'b1;
            rnotw_nx  = 1'b0;
            addr_nx   = cpu_addr;
            wdata_nx  = cpu_wdata;
          end else if (hit) begin
            ack_nx   = 1'b1;
            rdata_nx = hit_data;
          end else begin
            state_nx  = RD_ISSUE;
            strobe_nx = 1'b1;
            addr_nx   = cpu_addr;
          end
        end
      end
      WRITE: begin
        state_nx = IDLE;
        ack_nx   = 1'b1;
      end
      RD_ISSUE: begin
        state_nx = RD_WAIT;
        wdog_nx  = '0;
      end
      RD_WAIT: begin
        if (mem_mfc) begin
          state_nx = IDLE;
          ack_nx   = 1'b1;
          rdata_nx = mem_rdata;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          state_nx = IDLE;
          ack_nx   = 1'b1;
          err_nx   = 1'b1;
          rdata_nx = 16'hFFFF;
        end else begin
          wdog_nx = wdog + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wdog       <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mem_strobe <= 1'b0;
      mem_rnotw  <= 1'b1;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      wdog       <= wdog_nx;
      ack        <= ack_nx;
      err        <= err_nx;
      busy       <= busy_nx;
      mem_strobe <= strobe_nx;
      mem_rnotw  <= rnotw_nx;
      cpu_rdata  <= rdata_nx;
      mem_addr   <= addr_nx;
      mem_wdata  <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_slowmem_master.sv
// Bench for slowmem_master: slowmem model with MEMDELAY=4, cache/memory reference
// model, directed scenarios followed by randomized load/store/flush traffic.
module tb_slowmem_master;
`ifdef SLOWMEM_MASTER_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int MISS_LAT = 6;
  localparam int TO_LAT   = 17;

  logic        clk = 1'b0;
  logic        reset, req, we, flush;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        ack, err, busy, mem_rnotw, mem_strobe, mem_mfc;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mfc_raw, mfc_block;
  logic [15:0] rd_addr;
  int          cnt;
  logic [15:0] smem    [0:1023];
  logic [15:0] ref_mem [0:1023];
  bit          ref_valid [8];
  logic [12:0] ref_tag   [8];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  slowmem_master dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .flush(flush), .ack(ack), .err(err),
    .cpu_rdata(cpu_rdata), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rnotw(mem_rnotw), .mem_strobe(mem_strobe),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  assign mem_mfc = mfc_raw & ~mfc_block;

  // slowmem: latches on a strobed edge, mfc high MEMDELAY cycles later for one cycle.
  initial begin
    for (int i = 0; i < 1024; i++) smem[i] = 16'(i) ^ 16'h5A5A;
    smem[16] = 16'h1234;
    mfc_raw   <= 1'b0;
    mem_rdata <= 16'h0;
    rd_addr   <= 16'h0;
    cnt       <= 0;
    forever begin
      @(posedge clk);
      if (mem_strobe === 1'b1 && mem_rnotw === 1'b1) begin
        rd_addr <= mem_addr;
        cnt     <= 4;
        mfc_raw <= 1'b0;
      end else begin
        if (mem_strobe === 1'b1) smem[mem_addr[9:0]] <= mem_wdata;
        if (cnt > 0) cnt <= cnt - 1;
        mfc_raw <= (cnt == 1);
        if (cnt == 1) mem_rdata <= smem[rd_addr[9:0]];
      end
    end
  end

  task automatic model_clear();
    for (int j = 0; j < 8; j++) ref_valid[j] = 1'b0;
  endtask

  task automatic model_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic fl, output int elat, output logic [15:0] edata);
    int i;
    i = int'(a[2:0]);
    if (fl) model_clear();
    edata = ref_mem[a[9:0]];
    if (w) begin
      ref_mem[a[9:0]] = d;
      edata = d;
      if (CACHE) begin ref_valid[i] = 1'b1; ref_tag[i] = a[15:3]; end
      elat = 1;
    end else if (CACHE && ref_valid[i] && ref_tag[i] == a[15:3]) begin
      elat = 0;
    end else begin
      elat = MISS_LAT;
      if (CACHE) begin ref_valid[i] = 1'b1; ref_tag[i] = a[15:3]; end
    end
  endtask

  // Called at a negedge; returns the number of edges after the accept edge until ack.
  task automatic run_op(input logic w, input logic [15:0] a, input logic [15:0] d, input logic fl,
                        output int lat, output logic [15:0] rd, output logic e, output int nstb,
                        output logic s_rnotw, output logic [15:0] s_addr, output logic [15:0] s_wdata,
                        output logic bsy, output logic ack_after);
    req = 1'b1; we = w; cpu_addr = a; cpu_wdata = d; flush = fl;
    lat = -1; rd = 16'hxxxx; e = 1'bx; nstb = 0; bsy = 1'b0;
    s_rnotw = 1'bx; s_addr = 16'hxxxx; s_wdata = 16'hxxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (busy === 1'b1) bsy = 1'b1;
      if (mem_strobe === 1'b1) begin
        nstb++; s_rnotw = mem_rnotw; s_addr = mem_addr; s_wdata = mem_wdata;
      end
      if (ack === 1'b1) begin
        lat = k; rd = cpu_rdata; e = err;
        break;
      end
    end
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    ack_after = ack;
  endtask

  int          lat, elat, nstb;
  logic [15:0] rd, edata, s_addr, s_wdata;
  logic        e, s_rnotw, bsy, ack2;
  logic [52:0] obs;
  localparam logic [52:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0};

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; flush = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    mfc_block = 1'b0;
    repeat (3) @(negedge clk);
    obs = {ack, err, busy, mem_strobe, mem_rnotw, cpu_rdata, mem_addr, mem_wdata};
    vectors++; if (obs !== RST_VEC) begin miscompares++; $display("FAIL reset_vals got %h exp %h", obs, RST_VEC); end
    reset = 1'b0;
    @(negedge clk);
    obs = {ack, err, busy, mem_strobe, mem_rnotw, cpu_rdata, mem_addr, mem_wdata};
    vectors++; if (obs !== RST_VEC) begin miscompares++; $display("FAIL idle_after_reset got %h exp %h", obs, RST_VEC); end
    model_clear();
  endtask

  task automatic test_load_miss();
    model_op(1'b0, 16'h0010, 16'h0, 1'b0, elat, edata);
    run_op(1'b0, 16'h0010, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if (lat !== MISS_LAT) begin miscompares++; $display("FAIL miss_lat got %0d exp %0d", lat, MISS_LAT); end
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL miss_data got %h exp 1234", rd); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL miss_err got %b exp 0", e); end
    vectors++; if (nstb !== 1) begin miscompares++; $display("FAIL miss_strobes got %0d exp 1", nstb); end
    vectors++; if ({s_rnotw, s_addr} !== {1'b1, 16'h0010}) begin miscompares++; $display("FAIL miss_bus got %b/%h exp 1/0010", s_rnotw, s_addr); end
    vectors++; if (ack2 !== 1'b0) begin miscompares++; $display("FAIL miss_ack_pulse got %b exp 0", ack2); end
  endtask

  task automatic test_load_repeat();
    model_op(1'b0, 16'h0010, 16'h0, 1'b0, elat, edata);
    run_op(1'b0, 16'h0010, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if (lat !== elat) begin miscompares++; $display("FAIL repeat_lat got %0d exp %0d", lat, elat); end
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL repeat_data got %h exp 1234", rd); end
    vectors++; if (nstb !== (elat == 0 ? 0 : 1)) begin miscompares++; $display("FAIL repeat_strobes got %0d exp %0d", nstb, (elat == 0 ? 0 : 1)); end
    vectors++; if (bsy !== (elat != 0)) begin miscompares++; $display("FAIL repeat_busy got %b exp %b", bsy, (elat != 0)); end
  endtask

  task automatic test_store();
    model_op(1'b1, 16'h0010, 16'hBEEF, 1'b0, elat, edata);
    run_op(1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL store_lat got %0d exp 1", lat); end
    vectors++; if (nstb !== 1) begin miscompares++; $display("FAIL store_strobes got %0d exp 1", nstb); end
    vectors++; if ({s_rnotw, s_addr, s_wdata} !== {1'b0, 16'h0010, 16'hBEEF}) begin miscompares++; $display("FAIL store_bus got %b/%h/%h exp 0/0010/beef", s_rnotw, s_addr, s_wdata); end
    vectors++; if (smem[16] !== 16'hBEEF) begin miscompares++; $display("FAIL store_memword got %h exp beef", smem[16]); end
    vectors++; if (ack2 !== 1'b0) begin miscompares++; $display("FAIL store_ack_pulse got %b exp 0", ack2); end
    model_op(1'b0, 16'h0010, 16'h0, 1'b0, elat, edata);
    run_op(1'b0, 16'h0010, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if (lat !== elat) begin miscompares++; $display("FAIL store_reload_lat got %0d exp %0d", lat, elat); end
    vectors++; if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL store_reload_data got %h exp beef", rd); end
  endtask

  task automatic test_conflict();
    logic [15:0] seq_addr [6];
    logic        seq_fl   [6];
    seq_addr = '{16'h0018, 16'h0010, 16'h0018, 16'h0018, 16'h0018, 16'h0018};
    seq_fl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      if (s == 3) begin
        flush = 1'b1; @(negedge clk); flush = 1'b0; @(negedge clk);
        model_clear();
      end
      model_op(1'b0, seq_addr[s], 16'h0, seq_fl[s], elat, edata);
      run_op(1'b0, seq_addr[s], 16'h0, seq_fl[s], lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL conflict_lat step%0d got %0d exp %0d", s, lat, elat); end
      vectors++; if (rd !== edata) begin miscompares++; $display("FAIL conflict_data step%0d got %h exp %h", s, rd, edata); end
    end
  endtask

  task automatic test_timeout();
    mfc_block = 1'b1;
    run_op(1'b0, 16'h0040, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    mfc_block = 1'b0;
    vectors++; if (lat !== TO_LAT) begin miscompares++; $display("FAIL timeout_lat got %0d exp %0d", lat, TO_LAT); end
    vectors++; if ({e, rd} !== {1'b1, 16'hFFFF}) begin miscompares++; $display("FAIL timeout_result got %b/%h exp 1/ffff", e, rd); end
    vectors++; if ({busy, err, ack2} !== 3'b000) begin miscompares++; $display("FAIL timeout_idle got %b exp 000", {busy, err, ack2}); end
    model_op(1'b0, 16'h0040, 16'h0, 1'b0, elat, edata);
    run_op(1'b0, 16'h0040, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if ({lat, e, rd} !== {elat, 1'b0, edata}) begin miscompares++; $display("FAIL timeout_reload got %0d/%b/%h exp %0d/0/%h", lat, e, rd, elat, edata); end
  endtask

  task automatic test_reset_mid();
    int stray;
    req = 1'b1; we = 1'b0; cpu_addr = 16'h0025;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    obs = {ack, err, busy, mem_strobe, mem_rnotw, cpu_rdata, mem_addr, mem_wdata};
    vectors++; if (obs !== RST_VEC) begin miscompares++; $display("FAIL midreset_vals got %h exp %h", obs, RST_VEC); end
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack !== 1'b0 || busy !== 1'b0 || mem_strobe !== 1'b0) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL midreset_stray_mfc got %0d active cycles exp 0", stray); end
    model_op(1'b0, 16'h0025, 16'h0, 1'b0, elat, edata);
    run_op(1'b0, 16'h0025, 16'h0, 1'b0, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
    vectors++; if ({lat, e, rd} !== {elat, 1'b0, edata}) begin miscompares++; $display("FAIL midreset_reload got %0d/%b/%h exp %0d/0/%h", lat, e, rd, elat, edata); end
  endtask

  task automatic test_random();
    logic        w, fl;
    logic [15:0] a, d;
    for (int n = 0; n < 60; n++) begin
      w  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 7) == 0);
      a  = 16'h0100 | 16'($urandom_range(0, 3) << 3) | 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      model_op(w, a, d, fl, elat, edata);
      run_op(w, a, d, fl, lat, rd, e, nstb, s_rnotw, s_addr, s_wdata, bsy, ack2);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL rnd_lat op%0d we=%b a=%h got %0d exp %0d", n, w, a, lat, elat); end
      vectors++; if ({nstb, bsy, ack2, e} !== {(elat == 0 ? 0 : 1), (elat != 0), 1'b0, 1'b0}) begin miscompares++; $display("FAIL rnd_ctrl op%0d strobes=%0d busy=%b ackafter=%b err=%b exp lat %0d", n, nstb, bsy, ack2, e, elat); end
      if (w) begin
        vectors++; if ({s_rnotw, s_addr, s_wdata} !== {1'b0, a, d}) begin miscompares++; $display("FAIL rnd_store_bus op%0d got %b/%h/%h exp 0/%h/%h", n, s_rnotw, s_addr, s_wdata, a, d); end
      end else begin
        vectors++; if (rd !== edata) begin miscompares++; $display("FAIL rnd_load_data op%0d a=%h got %h exp %h", n, a, rd, edata); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;
    ref_mem[16] = 16'h1234;
    test_reset();
    test_load_miss();
    test_load_repeat();
    test_store();
    test_conflict();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
